mp_subtractor: RTL and testbench

Word-serial multi-precision subtractor computing iOpA − iOpB over OPERAND_WIDTH bits, one ADDER_WIDTH-bit slice per clock, least-significant word first. It is the inverse-operation companion to the team's word-serial multi-precision adder and shares its start/done handshake and LSW-first shift datapath. It produces the difference, a final borrow (set when A < B) and a zero flag, for use by modular-reduction and compare steps in the big-number arithmetic path.

---
 rtl/mp_arith_pkg.sv | 26 ++
 rtl/mp_subtractor_sub_word.sv | 21 ++
 rtl/mp_subtractor.sv | 113 +++++++++++
 tb/tb_mp_subtractor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mp_arith_pkg.sv
// Shared definitions for the word-serial multi-precision arithmetic units
// (adder and subtractor): FSM state encoding and iteration/counter sizing helpers.
package mp_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SUB  = 2'b01,
        DONE = 2'b10
    } arithState_e;

    // Number of word-serial passes needed to cover the whole operand.
    function automatic int nIterations(input int operandWidth, input int adderWidth);
        return operandWidth / adderWidth;
    endfunction

    // One spare bit so the counter can represent N_ITERATIONS itself.
    function automatic int counterWidth(input int iterations);
        return $clog2(iterations) + 1;
    endfunction

    localparam int DEFAULT_OPERAND_WIDTH = 512;
    localparam int DEFAULT_ADDER_WIDTH   = 32;
    localparam int DEFAULT_N_ITERATIONS  = DEFAULT_OPERAND_WIDTH / DEFAULT_ADDER_WIDTH;
    localparam int DEFAULT_COUNTER_WIDTH = $clog2(DEFAULT_N_ITERATIONS) + 1;

endpackage

// File: rtl/mp_subtractor_sub_word.sv
// Single-slice subtractor: A - B - borrowIn computed as A + ~B + ~borrowIn,
// so the outgoing borrow is the inverse of the adder carry-out.
module sub_word #(
    parameter int ADDER_WIDTH = 32
) (
    input  logic [ADDER_WIDTH-1:0] iA,
    input  logic [ADDER_WIDTH-1:0] iB,
    input  logic                   iBorrow,
    output logic [ADDER_WIDTH-1:0] oDiff,
    output logic                   oBorrow
);

    logic [ADDER_WIDTH:0] sum;

    always_comb begin
        sum     = {1'b0, iA} + {1'b0, ~iB} + {{ADDER_WIDTH{1'b0}}, ~iBorrow};
        oDiff   = sum[ADDER_WIDTH-1:0];
        oBorrow = ~sum[ADDER_WIDTH];
    end

endmodule

// File: rtl/mp_subtractor.sv
// Word-serial multi-precision subtractor: computes iOpA - iOpB one ADDER_WIDTH
// slice per clock, LSW first, reporting final borrow (A < B) and a zero flag.
module mp_subtractor
    import mp_arith_pkg::*;
#(
    parameter int OPERAND_WIDTH = 512,
    parameter int ADDER_WIDTH   = 32
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iStart,
    input  logic [OPERAND_WIDTH-1:0] iOpA,
    input  logic [OPERAND_WIDTH-1:0] iOpB,
    output logic [OPERAND_WIDTH-1:0] oRes,
    output logic                     oBorrow,
    output logic                     oZero,
    output logic                     oBusy,
    output logic                     oDone
);

    localparam int N_ITERATIONS = nIterations(OPERAND_WIDTH, ADDER_WIDTH);
    localparam int CNT_W        = counterWidth(N_ITERATIONS);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N_ITERATIONS - 1);

    arithState_e state;
    arithState_e stateNext;

    logic [OPERAND_WIDTH-1:0] regA;
    logic [OPERAND_WIDTH-1:0] regB;
    logic [OPERAND_WIDTH-1:0] regResult;
    logic [CNT_W-1:0]         counter;
    logic                     borrow;
    logic                     zeroAcc;
    logic                     resultValid;

    logic [ADDER_WIDTH-1:0]   sliceDiff;
    logic                     sliceBorrow;
    logic                     lastIter;

    sub_word #(
        .ADDER_WIDTH(ADDER_WIDTH)
    ) uSubWord (
        .iA      (regA[ADDER_WIDTH-1:0]),
        .iB      (regB[ADDER_WIDTH-1:0]),
        .iBorrow (borrow),
        .oDiff   (sliceDiff),
        .oBorrow (sliceBorrow)
    );

    assign lastIter = (counter == LAST_COUNT);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iStart) stateNext = SUB;
            SUB:     if (lastIter) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Operands shift right each pass while the result fills from the MSB end,
    // so after N_ITERATIONS passes the difference is fully aligned.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            regA        <= '0;
            regB        <= '0;
            regResult   <= '0;
            counter     <= '0;
            borrow      <= 1'b0;
            zeroAcc     <= 1'b0;
            resultValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        regA        <= iOpA;
                        regB        <= iOpB;
                        counter     <= '0;
                        borrow      <= 1'b0;
                        zeroAcc     <= 1'b1;
                        resultValid <= 1'b0;
                    end
                end
                SUB: begin
                    regResult <= {sliceDiff, regResult[OPERAND_WIDTH-1:ADDER_WIDTH]};
                    regA      <= {{ADDER_WIDTH{1'b0}}, regA[OPERAND_WIDTH-1:ADDER_WIDTH]};
                    regB      <= {{ADDER_WIDTH{1'b0}}, regB[OPERAND_WIDTH-1:ADDER_WIDTH]};
                    borrow    <= sliceBorrow;
                    zeroAcc   <= zeroAcc & (sliceDiff == '0);
                    counter   <= counter + CNT_W'(1);
                    if (lastIter) resultValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign oRes    = regResult;
    assign oBorrow = borrow;
    assign oZero   = zeroAcc & ((state == DONE) | resultValid);
    assign oBusy   = (state == SUB) | (state == DONE);
    assign oDone   = (state == DONE);

endmodule

// File: tb/tb_mp_subtractor.sv
// Self-checking bench for mp_subtractor (128-bit operands, 32-bit slices):
// directed corner cases plus random operands against a plain-arithmetic model.
module tb_mp_subtractor;

    localparam int OW  = 128;
    localparam int AW  = 32;
    localparam int NIT = OW / AW;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iStart;
    logic [OW-1:0] iOpA;
    logic [OW-1:0] iOpB;
    logic [OW-1:0] oRes;
    logic          oBorrow;
    logic          oZero;
    logic          oBusy;
    logic          oDone;

    int checks   = 0;
    int failures = 0;

    mp_subtractor #(
        .OPERAND_WIDTH(OW),
        .ADDER_WIDTH  (AW)
    ) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iOpA    (iOpA),
        .iOpB    (iOpB),
        .oRes    (oRes),
        .oBorrow (oBorrow),
        .oZero   (oZero),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: full-width unsigned subtraction with an extra bit for the borrow.
    task automatic refModel(input logic [OW-1:0] a, input logic [OW-1:0] b,
                            output logic [OW-1:0] diff, output logic brw, output logic zero);
        logic [OW:0] full;
        full = {1'b0, a} - {1'b0, b};
        diff = full[OW-1:0];
        brw  = (a < b);
        zero = (a == b);
    endtask

    task automatic applyStimulus(input logic [OW-1:0] a, input logic [OW-1:0] b);
        @(negedge iClk);
        iOpA   = a;
        iOpB   = b;
        iStart = 1'b1;
    endtask

    task automatic checkResult(input string tag, input logic [OW-1:0] a, input logic [OW-1:0] b);
        logic [OW-1:0] eDiff;
        logic          eBrw;
        logic          eZero;
        refModel(a, b, eDiff, eBrw, eZero);
        checkOutput({tag, ".res"}, oRes, eDiff);
        checkOutput({tag, ".borrow"}, {{(OW-1){1'b0}}, oBorrow}, {{(OW-1){1'b0}}, eBrw});
        checkOutput({tag, ".zero"}, {{(OW-1){1'b0}}, oZero}, {{(OW-1){1'b0}}, eZero});
    endtask

    task automatic runOp(input string tag, input logic [OW-1:0] a, input logic [OW-1:0] b);
        applyStimulus(a, b);
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        iOpA   = ~a;
        iOpB   = ~b;
        checkOutput({tag, ".busy0"}, {{(OW-1){1'b0}}, oBusy}, 1);
        for (int e = 1; e <= NIT; e++) begin
            @(posedge iClk);
            #1;
            if (e < NIT) begin
                checkOutput({tag, ".doneEarly"}, {{(OW-1){1'b0}}, oDone}, 0);
            end
        end
        checkOutput({tag, ".done"}, {{(OW-1){1'b0}}, oDone}, 1);
        checkResult(tag, a, b);
        @(posedge iClk);
        #1;
        checkOutput({tag, ".doneAfter"}, {{(OW-1){1'b0}}, oDone}, 0);
        checkOutput({tag, ".idle"}, {{(OW-1){1'b0}}, oBusy}, 0);
        checkResult({tag, ".held"}, a, b);
    endtask

    function automatic logic [OW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [OW-1:0] a1;
        logic [OW-1:0] b1;
        logic [OW-1:0] a2;
        logic [OW-1:0] b2;

        iRst   = 1'b1;
        iStart = 1'b0;
        iOpA   = '0;
        iOpB   = '0;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        checkOutput("reset.res", oRes, 0);
        checkOutput("reset.flags", {{(OW-4){1'b0}}, oBorrow, oZero, oBusy, oDone}, 0);

        runOp("small", 128'd5, 128'd3);
        runOp("negOne", 128'd0, 128'd1);
        runOp("wordBorrow", 128'h1_0000_0000, 128'd1);
        runOp("equal", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                       128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        runOp("afterZero", 128'd7, 128'd7 + 128'd1);

        for (int i = 0; i < 8; i++) begin
            a1 = rand128();
            b1 = rand128();
            if (i == 2) b1 = a1;
            if (i == 3) b1 = {a1[OW-1:AW], b1[AW-1:0]};
            runOp($sformatf("rand%0d", i), a1, b1);
        end

        // Operands change and iStart stays high through SUB and DONE.
        a1 = rand128();
        b1 = rand128();
        a2 = rand128();
        b2 = rand128();
        applyStimulus(a1, b1);
        @(posedge iClk);
        #1;
        iOpA = a2;
        iOpB = b2;
        for (int e = 1; e <= NIT; e++) begin
            @(posedge iClk);
            #1;
        end
        checkOutput("hold.done1", {{(OW-1){1'b0}}, oDone}, 1);
        checkResult("hold.first", a1, b1);
        @(posedge iClk);
        #1;
        checkOutput("hold.edge5busy", {{(OW-1){1'b0}}, oBusy}, 0);
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        checkOutput("hold.accept6", {{(OW-1){1'b0}}, oBusy}, 1);
        for (int e = 7; e <= 10; e++) begin
            @(posedge iClk);
            #1;
            if (e < 10) begin
                checkOutput("hold.doneEarly", {{(OW-1){1'b0}}, oDone}, 0);
            end
        end
        checkOutput("hold.done2", {{(OW-1){1'b0}}, oDone}, 1);
        checkResult("hold.second", a2, b2);
        @(posedge iClk);
        #1;
        checkOutput("hold.done2After", {{(OW-1){1'b0}}, oDone}, 0);

        // Reset lands on edge 2 of an operation.
        applyStimulus(128'd100, 128'd1);
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        @(posedge iClk);
        #1;
        iRst = 1'b1;
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        checkOutput("abort.res", oRes, 0);
        checkOutput("abort.flags", {{(OW-4){1'b0}}, oBorrow, oZero, oBusy, oDone}, 0);
        for (int e = 0; e < NIT + 2; e++) begin
            @(posedge iClk);
            #1;
            checkOutput("abort.noDone", {{(OW-2){1'b0}}, oBusy, oDone}, 0);
        end
        runOp("afterAbort", 128'd9, 128'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
